uart_rx: RTL and testbench

UART receiver stage that sits directly upstream of `interface_circuit`. It deserializes the asynchronous `i_rx` line using 16x oversampling ticks from the shared baud-rate generator. It delivers each received byte on `o_dout` together with a one-clock `o_rx_done_tick` strobe. Those two outputs drive `interface_circuit`'s `i_rx_data` and `i_rx_done_tick` inputs directly. It also flags malformed frames on `o_frame_err`.

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-line and byte-delivery signals between a UART line driver and uart_rx.
// The master side owns the line and baud tick; the receiver drives the byte/strobe outputs.
interface uart_rx_if #(
    parameter int unsigned DBIT = 8
);
    logic            i_rx;
    logic            i_s_tick;
    logic            o_rx_done_tick;
    logic [DBIT-1:0] o_dout;
    logic            o_frame_err;

    modport master (
        output i_rx,
        output i_s_tick,
        input  o_rx_done_tick,
        input  o_dout,
        input  o_frame_err
    );

    modport slave (
        input  i_rx,
        input  i_s_tick,
        output o_rx_done_tick,
        output o_dout,
        output o_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled deserializer delivering a byte plus a one-clock
// done strobe, or a one-clock framing-error strobe when the stop bit samples low.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic      i_clk,
    input  logic      i_reset,
    uart_rx_if.slave  bus
);
    localparam int unsigned S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int unsigned N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q;
    logic            rx_s_q;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    logic s_mid_c;
    logic s_bit_end_c;
    logic s_stop_end_c;
    logic n_last_c;

    assign s_mid_c      = (s_q == S_W'(7));
    assign s_bit_end_c  = (s_q == S_W'(15));
    assign s_stop_end_c = (s_q == S_W'(SB_TICK - 1));
    assign n_last_c     = (n_q == N_W'(DBIT - 1));

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= bus.i_rx;
            rx_s_q  <= sync1_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic; start detection is not tick-gated.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (bus.i_s_tick && s_mid_c) state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: begin
                if (bus.i_s_tick && s_bit_end_c && n_last_c) state_d = STOP;
            end
            STOP: begin
                if (bus.i_s_tick && s_stop_end_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, shift register and registered strobes.
    always_comb begin
        s_d    = s_q;
        n_d    = n_q;
        b_d    = b_q;
        dout_d = dout_q;
        done_d = 1'b0;
        ferr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) s_d = '0;
            end
            START: begin
                if (bus.i_s_tick) begin
                    if (s_mid_c) begin
                        if (!rx_s_q) begin
                            s_d = '0;
                            n_d = '0;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.i_s_tick) begin
                    if (s_bit_end_c) begin
                        s_d = '0;
                        b_d = DBIT'({rx_s_q, b_q} >> 1);
                        if (!n_last_c) n_d = n_q + N_W'(1);
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (bus.i_s_tick) begin
                    if (s_stop_end_c) begin
                        if (rx_s_q) begin
                            dout_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.o_dout         = dout_q;
    assign bus.o_rx_done_tick = done_q;
    assign bus.o_frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus hand-written glitch, reset,
// tick-gating and stop-length sequences, with ticks every 4 clocks.
module tb_uart_rx;
    logic clk;
    logic rst_n;
    logic rx;
    logic tick;
    logic tick_en;
    int   phase;
    int   tick_cnt;

    int total;
    int bad;

    uart_rx_if #(.DBIT(8)) bus ();
    uart_rx_if #(.DBIT(8)) bus32 ();

    assign bus.i_rx       = rx;
    assign bus.i_s_tick   = tick;
    assign bus32.i_rx     = rx;
    assign bus32.i_s_tick = tick;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus32.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe monitor, sampled 1 time unit after each rising edge.
    int         done_cnt, ferr_cnt, done32_cnt, viol;
    int         done_at, done32_at;
    logic [7:0] dout_at_done;
    logic       prev_strobe;

    initial begin
        done_cnt = 0; ferr_cnt = 0; done32_cnt = 0; viol = 0;
        done_at = 0; done32_at = 0; dout_at_done = 8'h00; prev_strobe = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        if (bus.o_rx_done_tick) begin
            done_cnt++;
            done_at = tick_cnt;
            dout_at_done = bus.o_dout;
        end
        if (bus.o_frame_err) ferr_cnt++;
        if (bus.o_rx_done_tick && bus.o_frame_err) viol++;
        if (prev_strobe && (bus.o_rx_done_tick || bus.o_frame_err)) viol++;
        prev_strobe = bus.o_rx_done_tick || bus.o_frame_err;
        if (bus32.o_rx_done_tick) begin
            done32_cnt++;
            done32_at = tick_cnt;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs change on the falling edge, tick every 4th clock.
    task automatic step();
        @(negedge clk);
        tick = tick_en && (phase == 3);
        phase = (phase + 1) % 4;
        if (tick) tick_cnt++;
    endtask

    task automatic send_bit(input logic v, input int nticks);
        int cnt;
        cnt = 0;
        rx = v;
        while (cnt < nticks) begin
            step();
            if (tick) cnt++;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int stop_ticks);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(data[i], 16);
        send_bit(stop, stop_ticks);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         stop_ticks;
        int         idle;
        logic [7:0] exp_dout;
        int         exp_done;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0, f0, d32;

        // Low stop bit is held across the sample point only, so the line is
        // high again before the re-armed START checks mid-bit.
        vecs[0] = '{8'h96, 1'b1, 16, 16, 8'h96, 1, 0};
        vecs[1] = '{8'h96, 1'b1, 16,  0, 8'h96, 1, 0};
        vecs[2] = '{8'h69, 1'b1, 16,  0, 8'h69, 1, 0};
        vecs[3] = '{8'h25, 1'b1, 16, 16, 8'h25, 1, 0};
        vecs[4] = '{8'h15, 1'b1, 16, 16, 8'h15, 1, 0};
        vecs[5] = '{8'h22, 1'b0, 10, 32, 8'h15, 0, 1};
        vecs[6] = '{8'h00, 1'b1, 16, 16, 8'h00, 1, 0};
        vecs[7] = '{8'hFF, 1'b1, 16, 16, 8'hFF, 1, 0};

        total = 0; bad = 0;
        rx = 1'b1; tick = 1'b0; tick_en = 1'b1; phase = 0; tick_cnt = 0;
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_dout", int'(bus.o_dout), 0);
        check("reset_done", int'(bus.o_rx_done_tick), 0);
        check("reset_ferr", int'(bus.o_frame_err), 0);
        check("reset_dout32", int'(bus32.o_dout), 0);
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt; f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].stop_ticks);
            if (vecs[i].idle > 0) send_bit(1'b1, vecs[i].idle);
            check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_dout", i), int'(bus.o_dout), int'(vecs[i].exp_dout));
            if (vecs[i].exp_done != 0)
                check($sformatf("vec%0d_dout_at_strobe", i), int'(dout_at_done), int'(vecs[i].exp_dout));
        end

        // Start glitch: 5 ticks low, then high.
        d0 = done_cnt; f0 = ferr_cnt;
        send_bit(1'b0, 5);
        send_bit(1'b1, 32);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_dout", int'(bus.o_dout), 8'hFF);

        // Reset during data bit 4 of 0xA5.
        d0 = done_cnt; f0 = ferr_cnt;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0, 16);
        send_bit(1'b0, 8);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", int'(bus.o_dout), 0);
        check("midrst_done", int'(bus.o_rx_done_tick), 0);
        check("midrst_ferr", int'(bus.o_frame_err), 0);
        rx = 1'b1;
        repeat (4) step();
        rst_n = 1'b1;
        check("midrst_no_strobe", (done_cnt - d0) + (ferr_cnt - f0), 0);
        send_frame(8'h3C, 1'b1, 16);
        send_bit(1'b1, 16);
        check("after_rst_done", done_cnt - d0, 1);
        check("after_rst_dout", int'(bus.o_dout), 8'h3C);

        // Tick gating: ticks stop for 100 clocks in the middle of data bit 3.
        d0 = done_cnt; f0 = ferr_cnt;
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(((8'hC3 >> i) & 8'h01) != 0, 16);
        send_bit(1'b0, 8);
        tick_en = 1'b0;
        repeat (100) step();
        check("gate_hold_strobes", (done_cnt - d0) + (ferr_cnt - f0), 0);
        tick_en = 1'b1;
        send_bit(1'b0, 8);
        for (int i = 4; i < 8; i++) send_bit(((8'hC3 >> i) & 8'h01) != 0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        check("gate_done", done_cnt - d0, 1);
        check("gate_ferr", ferr_cnt - f0, 0);
        check("gate_dout", int'(bus.o_dout), 8'hC3);

        // Stop length: two stop bits seen by both receivers.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        send_bit(1'b1, 4);
        d0 = done_cnt; f0 = ferr_cnt; d32 = done32_cnt;
        send_frame(8'h5A, 1'b1, 32);
        send_bit(1'b1, 16);
        check("sb16_done", done_cnt - d0, 1);
        check("sb16_ferr", ferr_cnt - f0, 0);
        check("sb32_done", done32_cnt - d32, 1);
        check("sb16_dout", int'(bus.o_dout), 8'h5A);
        check("sb32_dout", int'(bus32.o_dout), 8'h5A);
        check("sb32_delay_ticks", done32_at - done_at, 16);

        check("strobe_overlap_or_width", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
